imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the fetch path's instruction memory read port.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words to consecutive word-aligned instruction-memory addresses.
- Holds the core in reset (core_hold) until the program image is fully loaded.

Parameters:
- BASE_ADDR, 64'h0, byte address of the first instruction word written; must be 4-byte aligned.
- MEM_WORDS, 1024, instruction memory capacity in 32-bit words; upper bound on the accepted word count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- start  input  1  single-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle; a transfer happens when in_valid && in_ready.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  64  byte address of the write; always word-aligned.
- mem_wdata  output  32  instruction word being written.
- core_hold  output  1  high while a load is in progress; drives the core's fetch and pipeline reset.
- done  output  1  level, high after a successful load until the next start or reset.
- error  output  1  level, high after a rejected word count until the next start or reset.
- words_written  output  32  count of words written in the current or last load.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - in_ready, mem_we, core_hold, done, error = 0.
  - mem_addr = BASE_ADDR.
  - mem_wdata = 0; words_written = 0.
  - Byte counter and length register cleared.
- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start=1:
  - next state LEN; core_hold=1; done=0; error=0.
  - words_written=0; mem_addr=BASE_ADDR.
  - start in any other state is ignored.
- LEN:
  - in_ready=1.
  - Collects 4 bytes, first byte into bits [7:0], into the 32-bit word count N.
  - On the 4th accepted byte: N==0 -> DONE; N>MEM_WORDS -> ERR; otherwise -> DATA.
- DATA:
  - in_ready=1.
  - Collects 4 bytes into a word, little-endian.
  - On the 4th accepted byte the word is registered to mem_wdata and the next state is WRITE.
- WRITE (exactly one cycle):
  - in_ready=0; mem_we=1 with the current mem_addr and mem_wdata.
  - On exit: mem_addr += 4 (64-bit, no wrap check needed given the MEM_WORDS bound); words_written += 1.
  - Then DATA if words_written (after increment) < N, else DONE.
- Write cadence and stall tolerance:
  - mem_we is registered and never high outside WRITE.
  - Maximum rate is one write per 5 cycles (4 byte cycles + 1 write cycle).
  - in_valid gaps of any length stall LEN/DATA without loss; the partial word is held.
- DONE:
  - core_hold=0; done=1; in_ready=0.
  - mem_addr holds its last value + 4.
- ERR:
  - core_hold=0; error=1; in_ready=0; no writes were performed.
- Stream bytes presented while in_ready=0 are not consumed; the upstream source must hold them.
- Reset mid-load:
  - Immediate return to reset values.
  - Partially assembled word discarded; memory contents already written are left as is.
- core_hold transitions:
  - Rises the cycle after start is accepted.
  - Falls on entry to DONE or ERR.
- No other output depends combinationally on inputs. in_ready is a function of state only.

Test Plan:
- Reset then start; stream 01 00 00 00, 13 05 A0 00 -> one mem_we pulse, mem_addr=0x0, mem_wdata=0x00A00513. Then done=1, core_hold=0, words_written=1.
- N=3, words 0x00000013, 0x00100093, 0xFFDFF06F, BASE_ADDR=0x1000 -> writes at 0x1000, 0x1004, 0x1008 in order. words_written=3, done=1.
- Same N=3 load with in_valid toggled 0/1 randomly and held low 10 cycles mid-word -> identical write sequence and data; in_ready=0 during each WRITE cycle.
- N=0 (00 00 00 00) -> no mem_we; done=1 four byte-transfers after start; core_hold pulses high only during LEN.
- N=MEM_WORDS+1 (1025 = 01 04 00 00) -> error=1, done=0, no mem_we, in_ready=0. A later start clears error and a valid load succeeds.
- Assert rst=0 after 2 of 3 words are written -> all outputs return to reset values asynchronously. A new start with N=1 writes at BASE_ADDR with words_written=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: takes a little-endian word count, then
// that many little-endian words, and writes them to consecutive word addresses.
module imem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [31:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] ww_q, ww_d;
  logic        we_q, we_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        xfer;
  logic        last_byte;
  logic [31:0] full_word;

  assign xfer      = in_valid && in_ready;
  assign last_byte = xfer && (cnt_q == 2'd3);
  // Bytes shift in from the top so the first byte ends up in [7:0].
  assign full_word = {in_data, asm_q[31:8]};

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
      S_LEN: begin
        if (last_byte) begin
          if (full_word == 32'd0)                state_d = S_DONE;
          else if (full_word > 32'(MEM_WORDS))   state_d = S_ERR;
          else                                   state_d = S_DATA;
        end
      end
      S_DATA:  if (last_byte) state_d = S_WRITE;
      S_WRITE: state_d = ((ww_q + 32'd1) < len_q) ? S_DATA : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: in_ready decodes the current state, the rest are registered
  // from the next state so they change together with it.
  always_comb begin
    in_ready = (state_q == S_LEN) || (state_q == S_DATA);
    we_d     = (state_d == S_WRITE);
    hold_d   = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERR);
  end

  // Datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    ww_d    = ww_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          cnt_d  = 2'd0;
          addr_d = BASE_ADDR;
          ww_d   = 32'd0;
        end
      end
      S_LEN, S_DATA: begin
        if (xfer) begin
          asm_d = full_word;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (state_q == S_LEN) len_d   = full_word;
            else                  wdata_d = full_word;
          end
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 64'd4;
        ww_d   = ww_q + 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 2'd0;
      asm_q   <= 32'd0;
      len_q   <= 32'd0;
      wdata_q <= 32'd0;
      addr_q  <= BASE_ADDR;
      ww_q    <= 32'd0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      ww_q    <= ww_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign core_hold     = hold_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads plus hand-written
// sequences; expected writes go through a scoreboard queue.
module tb_imem_loader;

  localparam logic [63:0] BASE = 64'h1000;
  localparam int unsigned MW   = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [31:0] words_written;

  imem_loader #(.BASE_ADDR(BASE), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0]       n;
    logic [2:0][31:0]  w;
    bit                stall;
    bit                exp_done;
    bit                exp_err;
    logic [31:0]       exp_ww;
  } load_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  writes_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      writes_seen++;
      check("in_ready_low_in_write", {63'd0, in_ready}, 64'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was consumed.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 64'd1, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall, input bit long_gap);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = stall ? int'($urandom_range(0, 2)) : 0;
      if (long_gap && i == 2) g = 10;
      send_byte(w[8*i +: 8], g);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("core_hold_after_start", {63'd0, core_hold}, 64'd1);
    check("done_cleared", {63'd0, done}, 64'd0);
    check("error_cleared", {63'd0, error}, 64'd0);
    check("ww_cleared", {32'd0, words_written}, 64'd0);
    check("in_ready_len", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("end_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    check({tag, "_core_hold"}, {63'd0, core_hold}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_error"}, {63'd0, error}, 64'd0);
    check({tag, "_mem_addr"}, mem_addr, BASE);
    check({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
    check({tag, "_ww"}, {32'd0, words_written}, 64'd0);
  endtask

  load_t loads[6];

  initial begin
    loads[0] = '{32'd1,    {32'd0, 32'd0, 32'h00A00513}, 1'b0, 1'b1, 1'b0, 32'd1};
    loads[1] = '{32'd3,    {32'hFFDFF06F, 32'h00100093, 32'h00000013}, 1'b0, 1'b1, 1'b0, 32'd3};
    loads[2] = '{32'd3,    {32'hFFDFF06F, 32'h00100093, 32'h00000013}, 1'b1, 1'b1, 1'b0, 32'd3};
    loads[3] = '{32'd0,    {32'd0, 32'd0, 32'd0}, 1'b0, 1'b1, 1'b0, 32'd0};
    loads[4] = '{32'd1025, {32'd0, 32'd0, 32'd0}, 1'b0, 1'b0, 1'b1, 32'd0};
    loads[5] = '{32'd1,    {32'd0, 32'd0, 32'h12345678}, 1'b0, 1'b1, 1'b0, 32'd1};

    rst = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      int base_writes, nw;
      base_writes = writes_seen;
      nw = (loads[k].n <= MW) ? int'(loads[k].n) : 0;
      do_start();
      send_word(loads[k].n, loads[k].stall, 1'b0);
      if (loads[k].n == 32'd0) begin
        // Empty image: DONE is entered on the last count byte itself.
        check("n0_done_immediate", {63'd0, done}, 64'd1);
        check("n0_hold_fell", {63'd0, core_hold}, 64'd0);
      end
      if (loads[k].exp_err) begin
        check("err_immediate", {63'd0, error}, 64'd1);
        check("err_in_ready", {63'd0, in_ready}, 64'd0);
      end
      for (int i = 0; i < nw; i++) begin
        wr_t e;
        e.addr = BASE + 64'(4 * i);
        e.data = loads[k].w[i];
        sb_q.push_back(e);
        check("hold_during_load", {63'd0, core_hold}, 64'd1);
        send_word(loads[k].w[i], loads[k].stall, loads[k].stall && i == 1);
      end
      wait_end();
      @(negedge clk);
      check("done", {63'd0, done}, {63'd0, loads[k].exp_done});
      check("error", {63'd0, error}, {63'd0, loads[k].exp_err});
      check("core_hold_end", {63'd0, core_hold}, 64'd0);
      check("in_ready_end", {63'd0, in_ready}, 64'd0);
      check("words_written", {32'd0, words_written}, {32'd0, loads[k].exp_ww});
      check("write_count", 64'(writes_seen - base_writes), 64'(nw));
      check("final_addr", mem_addr, BASE + 64'(4 * nw));
      check("sb_empty", 64'(sb_q.size()), 64'd0);
    end

    // Reset in the middle of a 3-word load, after two words are written.
    do_start();
    send_word(32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      e.addr = BASE + 64'(4 * i);
      e.data = 32'hA000_0000 + 32'(i);
      sb_q.push_back(e);
      send_word(e.data, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("mid_ww_two", {32'd0, words_written}, 64'd2);
    send_byte(8'hEE, 0);
    #2 rst = 1'b0;
    #1 check_reset_vals("mid_reset");
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    begin
      wr_t e;
      e.addr = BASE;
      e.data = 32'hCAFE_F00D;
      do_start();
      send_word(32'd1, 1'b0, 1'b0);
      sb_q.push_back(e);
      send_word(e.data, 1'b0, 1'b0);
      wait_end();
      check("post_reset_done", {63'd0, done}, 64'd1);
      check("post_reset_ww", {32'd0, words_written}, 64'd1);
      check("post_reset_sb_empty", 64'(sb_q.size()), 64'd0);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
